// File: rtl/shape_renderer_pkg.sv
// shape_pkg: shared types and constants for the shape renderer.
// Eight-entry 4:4:4 palette, colour index type and the geometry box passed from the latch to the pixel pipe.
package shape_pkg;

    typedef logic [2:0]  colorIdx_t;
    typedef logic [11:0] rgb_t;

    localparam int BORDER_W = 2;

    // Palette order: red, green, blue, yellow, cyan, magenta, orange, white
    localparam rgb_t PALETTE [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hF80, 12'hFFF
    };

    typedef struct packed {
        logic [10:0] xStart;
        logic [10:0] xEnd;
        logic [10:0] yStart;
        logic [10:0] yEnd;
        logic        show;
    } shapeBox_t;

endpackage

// File: rtl/shape_renderer_if.sv
// shape_renderer_if: FSM shape command, VGA counters/syncs in, RGB and delayed syncs out.
// master = VGA/FSM side driving the renderer, slave = the renderer itself.
interface shape_renderer_if;

    logic [9:0] shapeX;
    logic [9:0] shapeY;
    logic [9:0] shapeSize;
    logic [9:0] countH;
    logic [9:0] countV;
    logic       active;
    logic       hSync;
    logic       vSync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hSyncOut;
    logic       vSyncOut;

    modport master (
        output shapeX, shapeY, shapeSize, countH, countV, active, hSync, vSync,
        input  red, green, blue, hSyncOut, vSyncOut
    );

    modport slave (
        input  shapeX, shapeY, shapeSize, countH, countV, active, hSync, vSync,
        output red, green, blue, hSyncOut, vSyncOut
    );

endinterface

// File: rtl/shape_renderer_param.sv
// shape_param_latch: once-per-frame shadow of the shape command, clipped edges, palette stepping.
// Latency: shadow updates the cycle after the first blanking line starts; no backpressure.
module shape_param_latch
    import shape_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int COLOR_PERIOD = 30
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [9:0] iCountH,
    input  logic [9:0] iCountV,
    input  logic [9:0] iShapeX,
    input  logic [9:0] iShapeY,
    input  logic [9:0] iShapeSize,
    output shapeBox_t  oBox,
    output colorIdx_t  oColorIdx
);

    localparam int             FCW        = (COLOR_PERIOD > 1) ? $clog2(COLOR_PERIOD) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(COLOR_PERIOD - 1);

    logic [9:0]     shX;
    logic [9:0]     shY;
    logic [9:0]     shSize;
    logic [FCW-1:0] frameCnt;
    logic           load;
    logic [10:0]    xSum;
    logic [10:0]    ySum;

    // Loading on the first blanking line keeps the whole visible frame on one set of parameters.
    assign load = (iCountV == 10'(HEIGHT)) && (iCountH == 10'd0);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            shX       <= '0;
            shY       <= '0;
            shSize    <= '0;
            frameCnt  <= '0;
            oColorIdx <= '0;
        end else if (load) begin
            shX    <= iShapeX;
            shY    <= iShapeY;
            shSize <= iShapeSize;
            if (frameCnt == FRAME_LAST) begin
                frameCnt  <= '0;
                oColorIdx <= oColorIdx + 3'd1;
            end else begin
                frameCnt <= frameCnt + FCW'(1);
            end
        end
    end

    assign xSum = {1'b0, shX} + {1'b0, shSize};
    assign ySum = {1'b0, shY} + {1'b0, shSize};

    always_comb begin
        oBox.xStart = {1'b0, shX};
        oBox.yStart = {1'b0, shY};
        oBox.xEnd   = (xSum > 11'(WIDTH))  ? 11'(WIDTH)  : xSum;
        oBox.yEnd   = (ySum > 11'(HEIGHT)) ? 11'(HEIGHT) : ySum;
        oBox.show   = (shSize != 10'd0) && ({1'b0, shX} < 11'(WIDTH)) && ({1'b0, shY} < 11'(HEIGHT));
    end

endmodule

// File: rtl/shape_renderer.sv
// shape_renderer: overlays a filled square on the VGA pixel stream (SHAPE_BORDER_EN adds a 2 px white border).
// Latency: RGB and syncs lag the counters by 2 cycles. Backpressure: none, one pixel per clock.
module shape_renderer
    import shape_pkg::*;
#(
    parameter int   WIDTH        = 640,
    parameter int   HEIGHT       = 480,
    parameter int   COLOR_PERIOD = 30,
    parameter rgb_t BG_COLOR     = 12'h000
) (
    input  logic            iClk,
    input  logic            iRst,
    shape_renderer_if.slave bus
);

    shapeBox_t   box;
    colorIdx_t   colorIdx;
    logic [10:0] pixH;
    logic [10:0] pixV;
    logic        pixInside;
    logic        insideQ;
    logic        activeQ;
    logic        hsQ;
    logic        vsQ;
    rgb_t        pixColor;

    shape_param_latch #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .COLOR_PERIOD (COLOR_PERIOD)
    ) uLatch (
        .iClk       (iClk),
        .iRst       (iRst),
        .iCountH    (bus.countH),
        .iCountV    (bus.countV),
        .iShapeX    (bus.shapeX),
        .iShapeY    (bus.shapeY),
        .iShapeSize (bus.shapeSize),
        .oBox       (box),
        .oColorIdx  (colorIdx)
    );

    assign pixH = {1'b0, bus.countH};
    assign pixV = {1'b0, bus.countV};

    // Right and bottom edges are exclusive, matching the clipped end coordinates.
    assign pixInside = box.show
                    && (pixH >= box.xStart) && (pixH < box.xEnd)
                    && (pixV >= box.yStart) && (pixV < box.yEnd);

`ifdef SHAPE_BORDER_EN
    logic pixBorder;
    logic borderQ;

    // Compare h+W against the end so a tiny shape near zero cannot underflow.
    assign pixBorder = (pixH < box.xStart + 11'(BORDER_W)) || (pixH + 11'(BORDER_W) >= box.xEnd)
                    || (pixV < box.yStart + 11'(BORDER_W)) || (pixV + 11'(BORDER_W) >= box.yEnd);

    always_ff @(posedge iClk) begin
        if (iRst) borderQ <= 1'b0;
        else      borderQ <= pixInside && pixBorder;
    end

    always_comb begin
        pixColor = BG_COLOR;
        if (!activeQ)     pixColor = '0;
        else if (insideQ) pixColor = borderQ ? 12'hFFF : PALETTE[colorIdx];
    end
`else
    always_comb begin
        pixColor = BG_COLOR;
        if (!activeQ)     pixColor = '0;
        else if (insideQ) pixColor = PALETTE[colorIdx];
    end
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            insideQ      <= 1'b0;
            activeQ      <= 1'b0;
            hsQ          <= 1'b1;
            vsQ          <= 1'b1;
            bus.red      <= '0;
            bus.green    <= '0;
            bus.blue     <= '0;
            bus.hSyncOut <= 1'b1;
            bus.vSyncOut <= 1'b1;
        end else begin
            insideQ      <= pixInside;
            activeQ      <= bus.active;
            hsQ          <= bus.hSync;
            vsQ          <= bus.vSync;
            bus.red      <= pixColor[11:8];
            bus.green    <= pixColor[7:4];
            bus.blue     <= pixColor[3:0];
            bus.hSyncOut <= hsQ;
            bus.vSyncOut <= vsQ;
        end
    end

endmodule

// File: tb/tb_shape_renderer.sv
// tb_shape_renderer: drives counters/syncs directly and scoreboards RGB+syncs two cycles later.
`timescale 1ns/1ps
module tb_shape_renderer;

    localparam int          W  = 640;
    localparam int          H  = 480;
    localparam logic [11:0] BG = 12'h123;
    localparam logic [11:0] PAL [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hF80, 12'hFFF
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shape_renderer_if bus();

    shape_renderer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .COLOR_PERIOD (2),
        .BG_COLOR     (BG)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [13:0] sb [$];
    int          loadCount = 0;
    int          ex0 = 0, ex1 = 0, ey0 = 0, ey1 = 0;
    bit          eshow = 1'b0;

    // Expected {rgb, hs, vs}; rectangle bounds are inclusive and set explicitly by each test.
    function automatic logic [13:0] expPix(int h, int v, bit act, bit hs, bit vs);
        logic [11:0] c;
        if (!act) c = 12'h000;
        else if (eshow && h >= ex0 && h <= ex1 && v >= ey0 && v <= ey1) begin
            c = PAL[(loadCount / 2) % 8];
`ifdef SHAPE_BORDER_EN
            if (h <= ex0 + 1 || h >= ex1 - 1 || v <= ey0 + 1 || v >= ey1 - 1) c = 12'hFFF;
`endif
        end else c = BG;
        return {c, hs, vs};
    endfunction

    // One pixel clock: drive, push expectation, return the output for the pixel driven one call earlier.
    task automatic drivePix(input int h, input int v, input bit act,
                            output bit have, output logic [13:0] want, output logic [13:0] got);
        bit hs, vs;
        hs = 1'(h & 1);
        vs = 1'(((h >> 1) ^ v) & 1);
        bus.countH = 10'(h);
        bus.countV = 10'(v);
        bus.active = act;
        bus.hSync  = hs;
        bus.vSync  = vs;
        sb.push_back(expPix(h, v, act, hs, vs));
        if (h == 0 && v == H) loadCount++;
        @(posedge clk);
        #1;
        got  = {bus.red, bus.green, bus.blue, bus.hSyncOut, bus.vSyncOut};
        have = (sb.size() >= 2);
        want = have ? sb.pop_front() : 14'h0;
    endtask

    task automatic test_reset();
        bit have; logic [13:0] want, got;
        bus.shapeX = 10'd100; bus.shapeY = 10'd50; bus.shapeSize = 10'd20;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.countH = 10'(105 + i); bus.countV = 10'd55; bus.active = 1'b1;
            bus.hSync = 1'b0; bus.vSync = 1'b0;
            @(posedge clk);
            #1;
            got = {bus.red, bus.green, bus.blue, bus.hSyncOut, bus.vSyncOut};
            checks++;
            if (got !== 14'b11) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, got, 14'b11);
            end
        end
        rst = 1'b0;
        sb.delete();
        loadCount = 0;
        eshow = 1'b0;
        for (int h = 95; h <= 125; h++) begin
            drivePix(h, 55, 1'b1, have, want, got);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL hidden h=%0d got=%h want=%h", h, got, want); end
            end
        end
    endtask

    task automatic test_fill();
        bit have; logic [13:0] want, got;
        int lines [9] = '{48, 49, 50, 51, 60, 68, 69, 70, 71};
        bus.shapeX = 10'd100; bus.shapeY = 10'd50; bus.shapeSize = 10'd20;
        drivePix(0, H, 1'b0, have, want, got);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL fill_load got=%h want=%h", got, want); end
        end
        ex0 = 100; ex1 = 119; ey0 = 50; ey1 = 69; eshow = 1'b1;
        foreach (lines[i]) begin
            for (int h = 97; h <= 122; h++) begin
                drivePix(h, lines[i], 1'b1, have, want, got);
                if (have) begin
                    checks++;
                    if (got !== want) begin errors++; $display("FAIL fill h=%0d v=%0d got=%h want=%h", h, lines[i], got, want); end
                end
            end
        end
    endtask

    task automatic test_clip();
        bit have; logic [13:0] want, got;
        int lines [9] = '{0, 1, 468, 469, 470, 471, 475, 478, 479};
        int h;
        bus.shapeX = 10'd630; bus.shapeY = 10'd470; bus.shapeSize = 10'd40;
        drivePix(0, H, 1'b0, have, want, got);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL clip_load got=%h want=%h", got, want); end
        end
        ex0 = 630; ex1 = 639; ey0 = 470; ey1 = 479; eshow = 1'b1;
        foreach (lines[i]) begin
            for (int k = 0; k < 19; k++) begin
                h = (k < 15) ? 625 + k : k - 15;
                drivePix(h, lines[i], 1'b1, have, want, got);
                if (have) begin
                    checks++;
                    if (got !== want) begin errors++; $display("FAIL clip h=%0d v=%0d got=%h want=%h", h, lines[i], got, want); end
                end
            end
        end
    endtask

    task automatic test_midframe();
        bit have; logic [13:0] want, got;
        bus.shapeX = 10'd100; bus.shapeY = 10'd50; bus.shapeSize = 10'd20;
        drivePix(0, H, 1'b0, have, want, got);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL mid_load1 got=%h want=%h", got, want); end
        end
        ex0 = 100; ex1 = 119; ey0 = 50; ey1 = 69; eshow = 1'b1;
        for (int v = 55; v <= 65; v++) begin
            if (v == 60) bus.shapeX = 10'd200;
            for (int h = 95; h <= 225; h += 2) begin
                drivePix(h, v, 1'b1, have, want, got);
                if (have) begin
                    checks++;
                    if (got !== want) begin errors++; $display("FAIL mid_old h=%0d v=%0d got=%h want=%h", h, v, got, want); end
                end
            end
        end
        drivePix(0, H, 1'b0, have, want, got);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL mid_load2 got=%h want=%h", got, want); end
        end
        ex0 = 200; ex1 = 219;
        for (int h = 95; h <= 225; h++) begin
            drivePix(h, 60, 1'b1, have, want, got);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL mid_new h=%0d got=%h want=%h", h, got, want); end
            end
        end
    endtask

    task automatic test_palette();
        bit have; logic [13:0] want, got;
        bus.shapeX = 10'd100; bus.shapeY = 10'd50; bus.shapeSize = 10'd20;
        while (loadCount < 17) begin
            drivePix(0, H, 1'b0, have, want, got);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL pal_load n=%0d got=%h want=%h", loadCount, got, want); end
            end
            ex0 = 100; ex1 = 119; ey0 = 50; ey1 = 69; eshow = 1'b1;
            for (int k = 0; k < 2; k++) begin
                drivePix((k == 0) ? 110 : 90, 60, 1'b1, have, want, got);
                if (have) begin
                    checks++;
                    if (got !== want) begin errors++; $display("FAIL palette n=%0d got=%h want=%h", loadCount, got, want); end
                end
            end
        end
    endtask

    task automatic test_size_zero();
        bit have; logic [13:0] want, got;
        bus.shapeX = 10'd100; bus.shapeY = 10'd50; bus.shapeSize = 10'd0;
        drivePix(0, H, 1'b0, have, want, got);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL zero_load got=%h want=%h", got, want); end
        end
        eshow = 1'b0;
        for (int h = 95; h <= 125; h++) begin
            drivePix(h, 60, 1'b1, have, want, got);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL size_zero h=%0d got=%h want=%h", h, got, want); end
            end
        end
    endtask

    initial begin
        bit have; logic [13:0] want, got;
        bus.shapeX = '0; bus.shapeY = '0; bus.shapeSize = '0;
        bus.countH = '0; bus.countV = '0; bus.active = 1'b0;
        bus.hSync = 1'b1; bus.vSync = 1'b1;
        test_reset();
        test_fill();
        test_clip();
        test_midframe();
        test_palette();
        test_size_zero();
        drivePix(1, 0, 1'b0, have, want, got);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL drain got=%h want=%h", got, want); end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
